// File: rtl/ekf_stage_seq.sv
// Host-side stage sequencer for the EKF-SLAM core: command FIFO, one-hot stage handshake, S-word capture.
// Optional STAGE_TIMEOUT_EN adds an ISSUE watchdog that abandons a stage after TMO_CYC cycles.
module ekf_stage_seq #(
  parameter int RSA_DW    = 32,
  parameter int RSA_AW    = 17,
  parameter int ROW_LEN   = 10,
  parameter int CMD_DEPTH = 4,
  parameter int S_WORDS   = 4,
  parameter int TMO_CYC   = 4096
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ROW_LEN-1:0] cmd_lk,
  input  logic [RSA_DW-1:0]  cmd_d0,
  input  logic [RSA_AW-1:0]  cmd_d1,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_AW-1:0]  alpha,
  output logic [RSA_AW-1:0]  phi,
  input  logic [RSA_DW-1:0]  S_data,
  output logic               s_valid,
  output logic [RSA_DW-1:0]  s_data,
  output logic [1:0]         s_idx,
  output logic               busy,
  output logic               err
);

  localparam int PW  = $clog2(CMD_DEPTH);
  localparam int EW  = 2 + ROW_LEN + RSA_DW + RSA_AW;
  localparam int SCW = $clog2(S_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_SCAP} state_t;

  state_t             r_state, w_next;
  logic [EW-1:0]      r_fifo [CMD_DEPTH];
  logic [PW:0]        r_wptr, r_rptr;
  logic               r_ready_en;
  logic [1:0]         r_op;
  logic [ROW_LEN-1:0] r_lk, r_lm;
  logic [RSA_DW-1:0]  r_d0, r_vlr, r_rk, r_s_data;
  logic [RSA_AW-1:0]  r_d1, r_alpha, r_phi;
  logic [ROW_LEN-1:0] r_l_k;
  logic               r_err, r_s_valid;
  logic [1:0]         r_s_idx;
  logic [SCW-1:0]     r_scnt;
  logic               w_empty, w_full, w_pop, w_push;
  logic [2:0]         w_onehot;
  logic               w_cmd_ok, w_match, w_tmo_hit;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign cmd_ready = r_ready_en && (!w_full || w_pop);
  assign w_push    = cmd_valid && cmd_ready;

  always_comb begin
    w_onehot = 3'b000;
    case (r_op)
      2'd0:    w_onehot = 3'b001;
      2'd1:    w_onehot = 3'b010;
      2'd2:    w_onehot = 3'b100;
      default: w_onehot = 3'b000;
    endcase
  end

  assign w_cmd_ok = (r_op != 2'd3) &&
                    !((r_op == 2'd2) && (r_lk >= r_lm)) &&
                    !((r_op == 2'd1) && (r_lm == '1));
  assign w_match  = (r_state == S_ISSUE) && |(stage_rdy & w_onehot);

`ifdef STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst)                r_tmo <= '0;
    else if (r_state == S_ISSUE) r_tmo <= r_tmo + TW'(1);
    else                         r_tmo <= '0;
  end

  assign w_tmo_hit = (r_state == S_ISSUE) && (r_tmo == TW'(TMO_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_LOAD;
      S_LOAD:  w_next = w_cmd_ok ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        if (w_match)        w_next = (r_op == 2'd2) ? S_SCAP : S_IDLE;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_SCAP:  if (r_scnt == SCW'(S_WORDS - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= {cmd_op, cmd_lk, cmd_d0, cmd_d1};
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ready_en <= 1'b0;
      r_op       <= '0;
      r_lk       <= '0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_l_k      <= '0;
      r_vlr      <= '0;
      r_rk       <= '0;
      r_alpha    <= '0;
      r_phi      <= '0;
      r_lm       <= '0;
      r_err      <= 1'b0;
      r_scnt     <= '0;
      r_s_valid  <= 1'b0;
      r_s_data   <= '0;
      r_s_idx    <= '0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
        {r_op, r_lk, r_d0, r_d1} <= r_fifo[r_rptr[PW-1:0]];
      end
      // Operands only change on an accepted command so they stay frozen through ISSUE.
      if (r_state == S_LOAD && w_cmd_ok) begin
        r_l_k <= r_lk;
        if (r_op == 2'd0) begin
          r_vlr   <= r_d0;
          r_alpha <= r_d1;
        end else begin
          r_rk  <= r_d0;
          r_phi <= r_d1;
        end
      end
      if ((r_state == S_LOAD && !w_cmd_ok) || (!w_match && w_tmo_hit)) r_err <= 1'b1;
      if (w_match && r_op == 2'd1) r_lm <= r_lm + ROW_LEN'(1);
      r_scnt    <= (r_state == S_SCAP) ? r_scnt + SCW'(1) : '0;
      r_s_valid <= (r_state == S_SCAP);
      if (r_state == S_SCAP) begin
        r_s_data <= S_data;
        r_s_idx  <= 2'(r_scnt);
      end
    end
  end

  assign stage_val    = (r_state == S_ISSUE) ? w_onehot : 3'b000;
  assign busy         = (r_state != S_IDLE) || !w_empty;
  assign err          = r_err;
  assign landmark_num = r_lm;
  assign l_k          = r_l_k;
  assign vlr          = r_vlr;
  assign rk           = r_rk;
  assign alpha        = r_alpha;
  assign phi          = r_phi;
  assign s_valid      = r_s_valid;
  assign s_data       = r_s_data;
  assign s_idx        = r_s_idx;

endmodule
